// File: rtl/ook_wave_gen.sv
// On-off-keyed baseband generator: serialises a 1024-bit frame, MSB first, into
// strobed signed I/Q samples that rotate a quarter turn on every strobe.
module ook_wave_gen #(
    parameter int unsigned SAMP_DIV = 8,
    parameter int unsigned SPB      = 1,
    parameter logic [15:0] AMP_ON   = 16'd16000,
    parameter logic [15:0] AMP_OFF  = 16'd0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               LOAD_EN,
    input  logic [3:0]         LOAD_ADDR,
    input  logic [63:0]        LOAD_DAT,
    input  logic               GEN_SRT,
    output logic               DDC_DEN,
    output logic signed [15:0] DDC_DATI,
    output logic signed [15:0] DDC_DATQ,
    output logic               Morse_out,
    output logic               GEN_BUSY,
    output logic               GEN_DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_FIN
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(SAMP_DIV - 1);
    localparam logic [15:0] SPB_LAST = 16'(SPB - 1);
    localparam logic [15:0] BIT_TOP  = 16'd1023;

    state_t             state_q, state_d;
    logic [1023:0]      frame_q, frame_d;
    logic [15:0]        bit_idx_q, bit_idx_d;
    logic [15:0]        sub_q, sub_d;
    logic [15:0]        div_q, div_d;
    logic [1:0]         phase_q, phase_d;
    logic               den_q, den_d;
    logic signed [15:0] dati_q, dati_d;
    logic signed [15:0] datq_q, datq_d;
    logic               morse_q, morse_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               cur_bit;
    logic signed [15:0] amp_cur;

    function automatic logic signed [15:0] neg16(input logic signed [15:0] a);
        return -a;
    endfunction

    function automatic logic signed [15:0] amp_sel(input logic b);
        return b ? $signed(AMP_ON) : $signed(AMP_OFF);
    endfunction

    assign cur_bit = frame_q[bit_idx_q[9:0]];
    assign amp_cur = amp_sel(cur_bit);

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_idx_d = bit_idx_q;
        sub_d     = sub_q;
        div_d     = div_q;
        phase_d   = phase_q;
        den_d     = 1'b0;
        dati_d    = dati_q;
        datq_d    = datq_q;
        morse_d   = morse_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Word 0 lands in the top 64 bits, word 15 in the bottom 64.
                if (LOAD_EN) begin
                    frame_d[{~LOAD_ADDR, 6'd0} +: 64] = LOAD_DAT;
                end
                if (GEN_SRT) begin
                    state_d   = S_SEND;
                    bit_idx_d = BIT_TOP;
                    sub_d     = 16'd0;
                    div_d     = 16'd0;
                    phase_d   = 2'd0;
                    busy_d    = 1'b1;
                end
            end
            S_SEND: begin
                if (div_q == DIV_LAST) begin
                    div_d   = 16'd0;
                    den_d   = 1'b1;
                    morse_d = cur_bit;
                    phase_d = phase_q + 2'd1;
                    unique case (phase_q)
                        2'd0: begin dati_d = amp_cur;        datq_d = 16'sd0;          end
                        2'd1: begin dati_d = 16'sd0;         datq_d = amp_cur;         end
                        2'd2: begin dati_d = neg16(amp_cur); datq_d = 16'sd0;          end
                        default: begin dati_d = 16'sd0;      datq_d = neg16(amp_cur);  end
                    endcase
                    if (sub_q == SPB_LAST) begin
                        sub_d = 16'd0;
                        if (bit_idx_q == 16'd0) begin
                            state_d = S_FIN;
                        end else begin
                            bit_idx_d = bit_idx_q - 16'd1;
                        end
                    end else begin
                        sub_d = sub_q + 16'd1;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                dati_d  = 16'sd0;
                datq_d  = 16'sd0;
                morse_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            bit_idx_q <= '0;
            sub_q     <= '0;
            div_q     <= '0;
            phase_q   <= '0;
            den_q     <= 1'b0;
            dati_q    <= '0;
            datq_q    <= '0;
            morse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_idx_q <= bit_idx_d;
            sub_q     <= sub_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            den_q     <= den_d;
            dati_q    <= dati_d;
            datq_q    <= datq_d;
            morse_q   <= morse_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign DDC_DEN   = den_q;
    assign DDC_DATI  = dati_q;
    assign DDC_DATQ  = datq_q;
    assign Morse_out = morse_q;
    assign GEN_BUSY  = busy_q;
    assign GEN_DONE  = done_q;

endmodule

// File: tb/tb_ook_wave_gen.sv
// Directed bench for ook_wave_gen: two instances (SPB=1/DIV=8/A=16000 and
// SPB=2/DIV=4/A=20000) driven through frame, abort, ignore and loopback cases.
module tb_ook_wave_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        rst    [2];
    logic        ld_en  [2];
    logic [3:0]  ld_addr[2];
    logic [63:0] ld_dat [2];
    logic        srt    [2];
    logic        den    [2];
    logic [15:0] di     [2];
    logic [15:0] dq     [2];
    logic        morse  [2];
    logic        busy   [2];
    logic        done   [2];

    ook_wave_gen #(.SAMP_DIV(8), .SPB(1), .AMP_ON(16'd16000), .AMP_OFF(16'd0)) u_dut0 (
        .CLK(clk), .RST(rst[0]), .LOAD_EN(ld_en[0]), .LOAD_ADDR(ld_addr[0]),
        .LOAD_DAT(ld_dat[0]), .GEN_SRT(srt[0]), .DDC_DEN(den[0]), .DDC_DATI(di[0]),
        .DDC_DATQ(dq[0]), .Morse_out(morse[0]), .GEN_BUSY(busy[0]), .GEN_DONE(done[0])
    );

    ook_wave_gen #(.SAMP_DIV(4), .SPB(2), .AMP_ON(16'd20000), .AMP_OFF(16'd0)) u_dut1 (
        .CLK(clk), .RST(rst[1]), .LOAD_EN(ld_en[1]), .LOAD_ADDR(ld_addr[1]),
        .LOAD_DAT(ld_dat[1]), .GEN_SRT(srt[1]), .DDC_DEN(den[1]), .DDC_DATI(di[1]),
        .DDC_DATQ(dq[1]), .Morse_out(morse[1]), .GEN_BUSY(busy[1]), .GEN_DONE(done[1])
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input int w, input string tag);
        chk({tag, "_den"},   den[w],   1'b0);
        chk({tag, "_dati"},  di[w],    16'd0);
        chk({tag, "_datq"},  dq[w],    16'd0);
        chk({tag, "_morse"}, morse[w], 1'b0);
        chk({tag, "_busy"},  busy[w],  1'b0);
        chk({tag, "_done"},  done[w],  1'b0);
    endtask

    task automatic load_word(input int w, input logic [3:0] a, input logic [63:0] d);
        ld_en[w] = 1'b1; ld_addr[w] = a; ld_dat[w] = d;
        tick;
        ld_en[w] = 1'b0;
    endtask

    task automatic load_frame(input int w, input logic [1023:0] fr);
        for (int i = 0; i < 16; i++) load_word(w, 4'(i), fr[1023 - 64*i -: 64]);
    endtask

    // Pulses GEN_SRT and follows the frame cycle by cycle against the reference frame.
    task automatic run_frame(input int w, input int spb, input int div, input logic [15:0] aon,
                             input logic [1023:0] fr, input int inject_at, input int abort_at,
                             output logic [1023:0] cap);
        int k, total, last;
        logic b;
        logic [1:0] p;
        logic [15:0] a, ei, eq;
        k = 0; total = 1024 * spb; last = div * total + 1; cap = '0;
        srt[w] = 1'b1;
        tick;
        srt[w] = 1'b0; ld_en[w] = 1'b0;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) begin
                tick;
                srt[w] = 1'b0; ld_en[w] = 1'b0;
            end
            chk("den_timing",  den[w],  (k < total) && (c == div * (k + 1)));
            chk("done_timing", done[w], c == last);
            chk("busy",        busy[w], c < last);
            if (den[w] && k < total) begin
                b  = fr[1023 - k / spb];
                p  = k[1:0];
                a  = b ? aon : 16'd0;
                ei = (p == 2'd0) ? a : (p == 2'd2) ? -a : 16'd0;
                eq = (p == 2'd1) ? a : (p == 2'd3) ? -a : 16'd0;
                chk("dati",  di[w],    ei);
                chk("datq",  dq[w],    eq);
                chk("morse", morse[w], b);
                if (k % spb == 0) cap[1023 - k / spb] = (di[w] != 16'd0) || (dq[w] != 16'd0);
                k++;
                if (k == inject_at) begin
                    srt[w] = 1'b1; ld_en[w] = 1'b1; ld_addr[w] = 4'd0; ld_dat[w] = 64'd0;
                end
                if (k == abort_at) begin
                    rst[w] = 1'b1;
                    #1;
                    chk_idle_outputs(w, "abort");
                    tick;
                    rst[w] = 1'b0;
                    tick;
                    chk("abort_no_done", done[w], 1'b0);
                    chk("abort_busy",    busy[w], 1'b0);
                    return;
                end
            end
            if (c == last) begin
                chk("fin_dati",  di[w],    16'd0);
                chk("fin_datq",  dq[w],    16'd0);
                chk("fin_morse", morse[w], 1'b0);
            end
        end
        chk("strobe_count", k, total);
        tick;
        chk("done_single", done[w], 1'b0);
        chk("idle_busy",   busy[w], 1'b0);
    endtask

    initial begin
        logic [1023:0] fr1, fr2, fr5, cap;
        logic [63:0] wv;

        for (int w = 0; w < 2; w++) begin
            rst[w] = 1'b0; ld_en[w] = 1'b0; ld_addr[w] = 4'd0; ld_dat[w] = 64'd0; srt[w] = 1'b0;
        end
        #2;
        rst[0] = 1'b1; rst[1] = 1'b1;
        tick;
        tick;
        chk_idle_outputs(0, "reset0");
        chk_idle_outputs(1, "reset1");
        rst[0] = 1'b0; rst[1] = 1'b0;
        tick;

        // Single all-ones word up front; DAT1 written on the same edge as the start.
        fr1 = {64'hFFFF_FFFF_FFFF_FFFF, 960'd0};
        for (int i = 1; i < 16; i++) load_word(0, 4'(i), 64'd0);
        ld_en[0] = 1'b1; ld_addr[0] = 4'd0; ld_dat[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_frame(0, 1, 8, 16'd16000, fr1, -1, -1, cap);

        // Restart and overwrite of DAT1 at strobe 100 must both be dropped.
        run_frame(0, 1, 8, 16'd16000, fr1, 100, -1, cap);

        // Abort at strobe 500 (first 64 strobes also confirm DAT1 survived), then replay cleared store.
        run_frame(0, 1, 8, 16'd16000, fr1, -1, 500, cap);
        run_frame(0, 1, 8, 16'd16000, 1024'd0, -1, -1, cap);

        // Alternating pattern with two samples per bit.
        fr2 = {16{64'hAAAA_AAAA_AAAA_AAAA}};
        load_frame(1, fr2);
        run_frame(1, 2, 4, 16'd20000, fr2, -1, -1, cap);

        // Loopback: envelope-threshold recovery must reproduce every loaded word.
        wv = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 16; i++) begin
            fr5[1023 - 64*i -: 64] = wv;
            wv = {wv[59:0], wv[63:60]};
        end
        load_frame(1, fr5);
        run_frame(1, 2, 4, 16'd20000, fr5, -1, -1, cap);
        for (int i = 0; i < 16; i++) chk("loopback_word", cap[1023 - 64*i -: 64], fr5[1023 - 64*i -: 64]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
